// File: rtl/m8_frame_sequencer.sv
// M8 frame filler slot scheduler: paces word requests, walks the slot pointer, counts frames into groups.
// Define SEQ_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is tied to zero.
module m8_frame_sequencer #(
  parameter int WORDS_PER_FRAME = 1024,
  parameter int GROUPS          = 32,
  parameter int CLK_PER_WORD    = 8
) (
  input  logic        reset,
  input  logic        clk,
  input  logic        start,
  input  logic        stop,
  input  logic        ser_ready,
  output logic        buf_get_word,
  output logic [9:0]  buf_rd_pointer,
  output logic [4:0]  cnt_grp,
  output logic        word_load,
  output logic        frame_start,
  output logic        group_start,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam int              DIV_W    = $clog2(CLK_PER_WORD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_WORD - 1);
  localparam logic [9:0]      PTR_LAST = 10'(WORDS_PER_FRAME - 1);
  localparam logic [4:0]      GRP_LAST = 5'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [9:0]       ptr_q;
  logic [4:0]       grp_q;
  logic             word_load_q;
  logic             underrun_q;

  logic slot_due;
  logic issue;
  logic wrap;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    slot_due = (state_q != IDLE) && (div_q == DIV_LAST);
    issue    = slot_due && ser_ready;
    wrap     = issue && (ptr_q == PTR_LAST);

    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop)  state_d = DRAIN;
      // A fresh start during the drain cancels the pending stop and wins over the frame end.
      DRAIN: begin
        if (start)     state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      ptr_q       <= '0;
      grp_q       <= '0;
      word_load_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // Filler has one cycle of latency from the get-word strobe to valid data.
      word_load_q <= issue;
      if (state_q == IDLE) begin
        div_q <= '0;
        if (start) begin
          ptr_q      <= '0;
          grp_q      <= '0;
          underrun_q <= 1'b0;
        end
      end else begin
        // The divider parks at terminal count while the serializer stalls a due slot.
        if (issue) begin
          div_q <= '0;
        end else if (!slot_due) begin
          div_q <= div_q + 1'b1;
        end

        if (slot_due && !ser_ready) begin
          underrun_q <= 1'b1;
        end

        if (issue) begin
          if (ptr_q == PTR_LAST) begin
            ptr_q <= '0;
            grp_q <= (grp_q == GRP_LAST) ? 5'd0 : grp_q + 5'd1;
          end else begin
            ptr_q <= ptr_q + 10'd1;
          end
        end
      end
    end
  end

`ifdef SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

  assign buf_get_word   = issue;
  assign buf_rd_pointer = ptr_q;
  assign cnt_grp        = grp_q;
  assign word_load      = word_load_q;
  assign frame_start    = issue && (ptr_q == 10'd0);
  assign group_start    = issue && (ptr_q == 10'd0) && (grp_q == 5'd0);
  assign busy           = (state_q != IDLE);
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_m8_frame_sequencer.sv
// Scoreboard bench for m8_frame_sequencer: directed phases push expected slots, a monitor pops and compares.
module tb_m8_frame_sequencer;

  localparam int CPW = 4;

`ifdef SEQ_FRAME_CNT_EN
  localparam int EXP_BIG_FC = 3;
`else
  localparam int EXP_BIG_FC = 0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        ser_ready;
  logic        buf_get_word;
  logic [9:0]  buf_rd_pointer;
  logic [4:0]  cnt_grp;
  logic        word_load;
  logic        frame_start;
  logic        group_start;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_cnt;

  logic        big_start;
  logic        big_stop;
  logic        big_ready;
  logic        big_get;
  logic [9:0]  big_ptr;
  logic [4:0]  big_grp;
  logic        big_wl;
  logic        big_fs;
  logic        big_gs;
  logic        big_busy;
  logic        big_ur;
  logic [15:0] big_fc;

  m8_frame_sequencer #(
    .WORDS_PER_FRAME(8),
    .GROUPS(4),
    .CLK_PER_WORD(CPW)
  ) dut (
    .reset(reset), .clk(clk), .start(start), .stop(stop), .ser_ready(ser_ready),
    .buf_get_word(buf_get_word), .buf_rd_pointer(buf_rd_pointer), .cnt_grp(cnt_grp),
    .word_load(word_load), .frame_start(frame_start), .group_start(group_start),
    .busy(busy), .underrun(underrun), .frame_cnt(frame_cnt)
  );

  m8_frame_sequencer #(
    .WORDS_PER_FRAME(1024),
    .GROUPS(32),
    .CLK_PER_WORD(CPW)
  ) dut_big (
    .reset(reset), .clk(clk), .start(big_start), .stop(big_stop), .ser_ready(big_ready),
    .buf_get_word(big_get), .buf_rd_pointer(big_ptr), .cnt_grp(big_grp),
    .word_load(big_wl), .frame_start(big_fs), .group_start(big_gs),
    .busy(big_busy), .underrun(big_ur), .frame_cnt(big_fc)
  );

  typedef struct {
    logic [9:0] ptr;
    logic [4:0] grp;
    logic       fs;
    logic       gs;
    int         gap;
  } slot_t;

  slot_t exp_q[$];
  int    n_vec;
  int    n_err;
  int    n_strobe;
  int    cyc;
  int    last_cyc;
  logic  prev_get;
  int    base;
  int    nfs;
  int    budget;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_slots(input int grp, input int lo, input int hi, input int first_gap);
    slot_t s;
    for (int p = lo; p <= hi; p++) begin
      s.ptr = 10'(p);
      s.grp = 5'(grp);
      s.fs  = (p == 0);
      s.gs  = (p == 0) && (grp == 0);
      s.gap = (p == lo) ? first_gap : CPW;
      exp_q.push_back(s);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int limit);
    int b;
    b = limit;
    while (n_strobe < target && b > 0) begin
      @(posedge clk);
      b--;
    end
    if (n_strobe < target) begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_timeout: got %0d strobes, expected %0d", n_strobe, target);
    end
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int b;
    b = limit;
    @(negedge clk);
    while (busy && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("idle_reached", 32'(busy), 32'd0);
    check("idle_pointer", 32'(buf_rd_pointer), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({busy, buf_get_word, word_load, frame_start, group_start, underrun,
                cnt_grp, buf_rd_pointer, frame_cnt});
  endfunction

  // Monitor: every strobe pops one expected slot; word_load must trail each strobe by one cycle.
  initial begin
    slot_t e;
    prev_get = 1'b0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_get = 1'b0;
      end else begin
        if (prev_get || word_load) check("word_load", 32'(word_load), 32'(prev_get));
        if (buf_get_word) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got pointer %0d grp %0d, expected no strobe",
                     buf_rd_pointer, cnt_grp);
          end else begin
            e = exp_q.pop_front();
            check("slot", 32'({buf_rd_pointer, cnt_grp, frame_start, group_start}),
                  32'({e.ptr, e.grp, e.fs, e.gs}));
            if (e.gap != 0) check("slot_gap", 32'(cyc - last_cyc), 32'(e.gap));
          end
          last_cyc = cyc;
          n_strobe++;
        end
        prev_get = buf_get_word;
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; n_strobe = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; ser_ready = 1'b1;
    big_start = 1'b0; big_stop = 1'b0; big_ready = 1'b1;

    // Reset state
    tick(3);
    @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    check("post_reset_outputs", all_outputs(), 32'd0);

    // Four full frames plus one, stop at pointer 3 of the fifth frame
    tick(1);
    base = n_strobe;
    push_slots(0, 0, 7, 0);
    push_slots(1, 0, 7, CPW);
    push_slots(2, 0, 7, CPW);
    push_slots(3, 0, 7, CPW);
    push_slots(0, 0, 7, CPW);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_strobes(base + 36, 400);
    pulse_stop();
    @(negedge clk);
    check("busy_in_drain", 32'(busy), 32'd1);
    wait_idle(100);
    tick(8);
    check("queue_after_drain", 32'(exp_q.size()), 32'd0);

    // Start during drain keeps the sequencer running into the next frame
    base = n_strobe;
    push_slots(0, 0, 7, 0);
    push_slots(1, 0, 7, CPW);
    pulse_start();
    wait_strobes(base + 3, 100);
    pulse_stop();
    tick(2);
    pulse_start();
    wait_strobes(base + 9, 100);
    @(negedge clk);
    check("busy_after_restart", 32'(busy), 32'd1);
    wait_strobes(base + 11, 100);
    pulse_stop();
    wait_idle(100);
    tick(8);
    check("queue_after_restart", 32'(exp_q.size()), 32'd0);

    // Serializer stall of 10 cycles at a due slot
    base = n_strobe;
    push_slots(0, 0, 1, 0);
    push_slots(0, 2, 2, 14);
    push_slots(0, 3, 7, CPW);
    pulse_start();
    @(negedge clk);
    check("underrun_cleared", 32'(underrun), 32'd0);
    wait_strobes(base + 2, 100);
    ser_ready = 1'b0;
    tick(6);
    @(negedge clk);
    check("underrun_during_stall", 32'(underrun), 32'd1);
    check("no_strobe_in_stall", 32'(buf_get_word), 32'd0);
    tick(7);
    ser_ready = 1'b1;
    @(negedge clk);
    check("strobe_on_ready", 32'(buf_get_word), 32'd1);
    tick(1);
    pulse_stop();
    wait_idle(100);
    check("underrun_sticky", 32'(underrun), 32'd1);
    tick(4);
    check("queue_after_stall", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at pointer 5
    base = n_strobe;
    push_slots(0, 0, 4, 0);
    pulse_start();
    @(negedge clk);
    check("underrun_cleared_again", 32'(underrun), 32'd0);
    wait_strobes(base + 5, 100);
    @(negedge clk);
    check("pointer_before_reset", 32'(buf_rd_pointer), 32'd5);
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_frame_reset_outputs", all_outputs(), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    @(negedge clk);
    check("after_release_outputs", all_outputs(), 32'd0);
    check("queue_after_reset", 32'(exp_q.size()), 32'd0);
    tick(1);
    base = n_strobe;
    push_slots(0, 0, 7, 0);
    pulse_start();
    wait_strobes(base + 3, 100);
    pulse_stop();
    wait_idle(100);
    tick(4);
    check("queue_after_resume", 32'(exp_q.size()), 32'd0);

    // Full-size frame: three pointer wraps
    big_start = 1'b1;
    tick(1);
    big_start = 1'b0;
    nfs = 0;
    budget = 20000;
    while (nfs < 4 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (big_get && big_fs) nfs++;
    end
    check("big_frames_seen", 32'(nfs), 32'd4);
    check("big_frame_cnt", 32'(big_fc), 32'(EXP_BIG_FC));
    check("big_cnt_grp", 32'(big_grp), 32'd3);
    check("big_pointer", 32'(big_ptr), 32'd0);
    check("big_underrun", 32'(big_ur), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
